// File: rtl/regfile_wb_arbiter_if.sv
// Write-back request bundle: ALU result path and data-memory load path,
// each a valid/ready handshake carrying a destination register and data.
interface regfile_wb_arbiter_if #(
  parameter int ADDRESS_WIDTH = 5,
  parameter int DATA_WIDTH    = 32
);
  logic                     alu_valid;
  logic                     alu_ready;
  logic [ADDRESS_WIDTH-1:0] alu_rd;
  logic [DATA_WIDTH-1:0]    alu_data;

  logic                     mem_valid;
  logic                     mem_ready;
  logic [ADDRESS_WIDTH-1:0] mem_rd;
  logic [DATA_WIDTH-1:0]    mem_data;

  // Requester side: execute/memory stages
  modport master (
    output alu_valid, alu_rd, alu_data,
    output mem_valid, mem_rd, mem_data,
    input  alu_ready, mem_ready
  );

  // Arbiter side
  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  mem_valid, mem_rd, mem_data,
    output alu_ready, mem_ready
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the register file's single write port (WE3/AD3/WD3)
// between the ALU write-back and the load write-back, keeps a scoreboard of
// pending destinations and raises a decode stall on read-after-write hazards.
// Default: loads always win. Optional macro RF_WB_FAIR_EN: after MAX_WAIT
// consecutive ALU losses the ALU is granted for one cycle.
module regfile_wb_arbiter #(
  parameter int ADDRESS_WIDTH = 5,
  parameter int DATA_WIDTH    = 32,
  parameter int MAX_WAIT      = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  regfile_wb_arbiter_if.slave      wb,
  input  logic                     issue_valid,
  input  logic [ADDRESS_WIDTH-1:0] issue_rd,
  input  logic [ADDRESS_WIDTH-1:0] rs1,
  input  logic [ADDRESS_WIDTH-1:0] rs2,
  output logic                     stall,
  output logic                     WE3,
  output logic [ADDRESS_WIDTH-1:0] AD3,
  output logic [DATA_WIDTH-1:0]    WD3,
  output logic [ADDRESS_WIDTH:0]   pend_cnt
);
  localparam int AW   = ADDRESS_WIDTH;
  localparam int DW   = DATA_WIDTH;
  localparam int NREG = 1 << AW;

  typedef struct packed {
    logic          vld;
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
  } wb_req_t;

  // A MAX_WAIT below 1 would starve the load path forever in fair mode
  if (MAX_WAIT < 1) begin : g_max_wait_chk
    $error("regfile_wb_arbiter: MAX_WAIT must be >= 1");
  end

  wb_req_t         alu_req, mem_req, win;
  logic            alu_rdy, mem_rdy;
  logic            alu_acc, mem_acc, wr_en;
  logic            force_alu;
  logic [NREG-1:0] pend, set_vec, clr_vec;
  logic            cnt_inc, cnt_dec;

  assign alu_req = '{vld: wb.alu_valid, rd: wb.alu_rd, data: wb.alu_data};
  assign mem_req = '{vld: wb.mem_valid, rd: wb.mem_rd, data: wb.mem_data};

`ifdef RF_WB_FAIR_EN
  localparam int WW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  logic [WW-1:0] wait_cnt;

  // Once the ALU has lost MAX_WAIT times in a row it takes the port this cycle
  assign force_alu = (wait_cnt >= WW'(MAX_WAIT));

  // Consecutive ALU losses; an ALU win or an idle ALU cycle restarts the count
  always_ff @(posedge clk) begin
    if (rst)                          wait_cnt <= '0;
    else if (alu_req.vld && !alu_rdy) wait_cnt <= wait_cnt + 1'b1;
    else                              wait_cnt <= '0;
  end
`else
  // Strict load priority: the ALU is never forced through
  assign force_alu = 1'b0;
`endif

  // Grant: load has priority unless the ALU has waited too long
  always_comb begin
    mem_rdy = 1'b1;
    alu_rdy = !mem_req.vld;
    if (force_alu) begin
      mem_rdy = 1'b0;
      alu_rdy = 1'b1;
    end
  end

  assign wb.alu_ready = alu_rdy;
  assign wb.mem_ready = mem_rdy;

  // Only one side can be accepted: alu_rdy implies the load is idle or blocked
  assign mem_acc = mem_req.vld && mem_rdy;
  assign alu_acc = alu_req.vld && alu_rdy && !mem_acc;
  assign win     = mem_acc ? mem_req : alu_req;
  // x0 writes complete the handshake but never reach the register file
  assign wr_en   = (mem_acc || alu_acc) && (win.rd != '0);

  // Registered write port; address/data hold when nothing is written
  always_ff @(posedge clk) begin
    if (rst) begin
      WE3 <= 1'b0;
      AD3 <= '0;
      WD3 <= '0;
    end else begin
      WE3 <= wr_en;
      if (wr_en) begin
        AD3 <= win.rd;
        WD3 <= win.data;
      end
    end
  end

  // Scoreboard set/clear one-hot vectors for this cycle
  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (issue_valid && issue_rd != '0) set_vec[issue_rd] = 1'b1;
    if (wr_en)                         clr_vec[win.rd]   = 1'b1;
  end

  // Count moves only on a real 0->1 or 1->0 transition; set beats clear
  assign cnt_inc = |(set_vec & ~pend);
  assign cnt_dec = |(clr_vec & pend & ~set_vec);

  // Pending-destination bits and their population count
  always_ff @(posedge clk) begin
    if (rst) begin
      pend     <= '0;
      pend_cnt <= '0;
    end else begin
      pend     <= (pend & ~clr_vec) | set_vec;
      pend_cnt <= pend_cnt + {{AW{1'b0}}, cnt_inc} - {{AW{1'b0}}, cnt_dec};
    end
  end

  // RAW hazard from the registered scoreboard; x0 is never a hazard
  assign stall = ((rs1 != '0) && pend[rs1]) || ((rs2 != '0) && pend[rs2]);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios followed by
// randomized traffic, all compared against a behavioural scoreboard model.
`timescale 1ns/1ps
module tb_regfile_wb_arbiter;
  localparam int AW   = 5;
  localparam int DW   = 32;
  localparam int MW   = 4;
  localparam int NREG = 1 << AW;
`ifdef RF_WB_FAIR_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          issue_valid;
  logic [AW-1:0] issue_rd, rs1, rs2;
  logic          stall, WE3;
  logic [AW-1:0] AD3;
  logic [DW-1:0] WD3;
  logic [AW:0]   pend_cnt;

  regfile_wb_arbiter_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) wb ();

  regfile_wb_arbiter #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .MAX_WAIT(MW)) dut (
    .clk         (clk),
    .rst         (rst),
    .wb          (wb.slave),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .rs1         (rs1),
    .rs2         (rs2),
    .stall       (stall),
    .WE3         (WE3),
    .AD3         (AD3),
    .WD3         (WD3),
    .pend_cnt    (pend_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state
  bit            pend_m[NREG];
  bit            exp_we;
  logic [AW-1:0] exp_ad;
  logic [DW-1:0] exp_wd;
  bit            chk_data;
  int            losses;
  bit            known;
  bit            m_alu_rdy, m_mem_rdy, m_alu_acc, m_mem_acc;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int model_cnt();
    int n = 0;
    for (int i = 0; i < NREG; i++) n += int'(pend_m[i]);
    return n;
  endfunction

  function automatic bit model_stall(input logic [AW-1:0] a, input logic [AW-1:0] b);
    return (a != 0 && pend_m[a]) || (b != 0 && pend_m[b]);
  endfunction

  function automatic logic [AW-1:0] rand_rd();
    if ($urandom_range(0, 3) == 0) return AW'($urandom_range(0, NREG - 1));
    return AW'($urandom_range(0, 7));
  endfunction

  // One clock: check combinational outputs, advance the model, check registers.
  // Entered and left at the falling edge; inputs are set by the caller beforehand.
  task automatic cycle(input string tag);
    bit starved;
    #1;
    starved   = FAIR && wb.alu_valid && (losses >= MW);
    m_mem_rdy = !starved;
    m_alu_rdy = !wb.mem_valid || starved;
    if (known) begin
      chk({tag, ".alu_ready"}, wb.alu_ready, m_alu_rdy);
      chk({tag, ".mem_ready"}, wb.mem_ready, m_mem_rdy);
      chk({tag, ".stall"}, stall, model_stall(rs1, rs2));
    end
    m_mem_acc = wb.mem_valid && m_mem_rdy;
    m_alu_acc = wb.alu_valid && m_alu_rdy && !m_mem_acc;
    @(posedge clk);
    chk_data = 1'b0;
    if (rst) begin
      foreach (pend_m[i]) pend_m[i] = 1'b0;
      exp_we = 0; exp_ad = '0; exp_wd = '0; losses = 0;
      known = 1'b1; chk_data = 1'b1;
    end else begin
      exp_we = 0;
      if (m_mem_acc && wb.mem_rd != 0) begin
        exp_we = 1; exp_ad = wb.mem_rd; exp_wd = wb.mem_data;
        pend_m[wb.mem_rd] = 1'b0;
      end else if (m_alu_acc && wb.alu_rd != 0) begin
        exp_we = 1; exp_ad = wb.alu_rd; exp_wd = wb.alu_data;
        pend_m[wb.alu_rd] = 1'b0;
      end
      if (issue_valid && issue_rd != 0) pend_m[issue_rd] = 1'b1;
      if (wb.alu_valid && !m_alu_rdy) losses++;
      else losses = 0;
      chk_data = exp_we;
    end
    #1;
    if (known) begin
      chk({tag, ".WE3"}, WE3, exp_we);
      chk({tag, ".pend_cnt"}, pend_cnt, (AW+1)'(model_cnt()));
      if (chk_data) begin
        chk({tag, ".AD3"}, AD3, exp_ad);
        chk({tag, ".WD3"}, WD3, exp_wd);
      end
    end
    @(negedge clk);
  endtask

  task automatic idle();
    wb.alu_valid = 0; wb.mem_valid = 0; issue_valid = 0;
  endtask

  initial begin
    int cnt0;
    known = 0; losses = 0; exp_we = 0; exp_ad = '0; exp_wd = '0;
    rst = 1; issue_valid = 0; issue_rd = '0; rs1 = 5; rs2 = 5;
    wb.alu_valid = 0; wb.alu_rd = '0; wb.alu_data = '0;
    wb.mem_valid = 0; wb.mem_rd = '0; wb.mem_data = '0;
    @(negedge clk);

    // 1: reset
    cycle("t1a");
    cycle("t1b");
    chk("t1.AD3", AD3, 0);
    chk("t1.WD3", WD3, 0);
    chk("t1.stall", stall, 0);
    rst = 0;

    // 2: issue x5, ALU writes x5 two cycles later
    issue_valid = 1; issue_rd = 5; rs1 = 5; rs2 = 0;
    cycle("t2_iss");
    issue_valid = 0;
    chk("t2.stall_hi", stall, 1);
    cycle("t2_gap");
    wb.alu_valid = 1; wb.alu_rd = 5; wb.alu_data = 32'h1234;
    #1 chk("t2.alu_ready", wb.alu_ready, 1);
    cycle("t2_acc");
    wb.alu_valid = 0;
    chk("t2.WE3", WE3, 1);
    chk("t2.AD3", AD3, 5);
    chk("t2.WD3", WD3, 32'h1234);
    chk("t2.stall_lo", stall, 0);

    // 3: simultaneous requests, load wins then ALU
    wb.alu_valid = 1; wb.alu_rd = 3; wb.alu_data = 32'h55;
    wb.mem_valid = 1; wb.mem_rd = 7; wb.mem_data = 32'hBEEF;
    cycle("t3_mem");
    wb.mem_valid = 0;
    chk("t3.AD3_mem", AD3, 7);
    chk("t3.WD3_mem", WD3, 32'hBEEF);
    cycle("t3_alu");
    wb.alu_valid = 0;
    chk("t3.AD3_alu", AD3, 3);

    // 4: continuous loads against a waiting ALU
    wb.alu_valid = 1; wb.alu_rd = 11; wb.alu_data = 32'hA11;
    for (int i = 0; i < 6; i++) begin
      wb.mem_valid = 1; wb.mem_rd = AW'(12 + i); wb.mem_data = $urandom;
      if (i == 4) begin
        #1;
        chk("t4.alu_ready5", wb.alu_ready, FAIR);
        chk("t4.mem_ready5", wb.mem_ready, !FAIR);
      end
      cycle("t4");
      if (m_alu_acc) wb.alu_valid = 0;
    end
    wb.mem_valid = 0;
    cycle("t4_drain");
    wb.alu_valid = 0;

    // 5: x0 write-back and x0 issue
    cnt0 = model_cnt();
    wb.alu_valid = 1; wb.alu_rd = 0; wb.alu_data = 32'hFFFF;
    issue_valid = 1; issue_rd = 0;
    #1 chk("t5.alu_ready", wb.alu_ready, 1);
    cycle("t5");
    idle();
    chk("t5.WE3", WE3, 0);
    chk("t5.pend_cnt", pend_cnt, (AW+1)'(cnt0));

    // 6: set and clear of x9 together, then reset with a write in flight
    issue_valid = 1; issue_rd = 9; rs1 = 9;
    cycle("t6_iss");
    cnt0 = model_cnt();
    wb.mem_valid = 1; wb.mem_rd = 9; wb.mem_data = 32'h99;
    cycle("t6_both");
    idle();
    chk("t6.stall", stall, 1);
    chk("t6.pend_cnt", pend_cnt, (AW+1)'(cnt0));
    wb.mem_valid = 1; wb.mem_rd = 4; wb.mem_data = 32'h44; rst = 1;
    cycle("t6_rst");
    idle();
    rst = 0;
    chk("t6.WE3_rst", WE3, 0);

    // Randomized traffic with occasional resets
    for (int n = 0; n < 600; n++) begin
      if (!wb.alu_valid && $urandom_range(0, 2) == 0) begin
        wb.alu_valid = 1; wb.alu_rd = rand_rd(); wb.alu_data = $urandom;
      end
      if (!wb.mem_valid && $urandom_range(0, 2) == 0) begin
        wb.mem_valid = 1; wb.mem_rd = rand_rd(); wb.mem_data = $urandom;
      end
      issue_valid = 1'($urandom_range(0, 1));
      issue_rd = rand_rd(); rs1 = rand_rd(); rs2 = rand_rd();
      rst = ($urandom_range(0, 99) == 0);
      cycle("rnd");
      if (m_alu_acc || rst) wb.alu_valid = 0;
      if (m_mem_acc || rst) wb.mem_valid = 0;
      rst = 0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
